// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - single-port SRAM front end with power-up clear and 3-deep read response FIFO
module sram_port_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_n;
    logic [ADDR_W-1:0] init_cnt;
    logic              fire;
    logic              rd_fire;
    logic              pop;
    logic              in_flight;
    logic              ready_n;
    logic [1:0]        count;
    logic [1:0]        count_n;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [DATA_W-1:0] fifo_mem [3];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign fire       = req_valid && req_ready;
    assign rd_fire    = fire && !req_write;
    assign resp_valid = (count != 2'd0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = fifo_mem[rd_ptr];
    assign init_done  = (state == ST_RUN);

    // Next-state view used to register req_ready; the in-flight read lands in the FIFO next cycle.
    always_comb begin
        state_n = state;
        if (state == ST_INIT && init_cnt == ADDR_W'(DEPTH - 1)) begin
            state_n = ST_RUN;
        end
        count_n = count + {1'b0, in_flight} - {1'b0, pop};
        ready_n = (state_n == ST_RUN) && (({1'b0, count_n} + {2'b0, rd_fire}) < 3'd3);
    end

    // SRAM macro drive: clear writes during INIT, pass-through of a fired request in RUN.
    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = req_addr;
        sram_d   = req_data;
        if (!reset) begin
            if (state == ST_INIT) begin
                sram_ceb = 1'b0;
                sram_web = 1'b0;
                sram_a   = init_cnt;
                sram_d   = '0;
            end else if (fire) begin
                sram_ceb = 1'b0;
                sram_web = !req_write;
            end
        end
    end

    // Control state: mode, clear counter, read pipeline flag, FIFO pointers and registered ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            in_flight <= 1'b0;
            count     <= 2'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            req_ready <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + ADDR_W'(1);
            end
            in_flight <= rd_fire;
            count     <= count_n;
            if (in_flight) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            req_ready <= ready_n;
        end
    end

    // Capture read data from the macro only in the cycle after a read fired.
    always_ff @(posedge clock) begin
        if (in_flight) begin
            fifo_mem[wr_ptr] <= sram_q;
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - randomized and directed self-checking bench for sram_port_ctrl
module tb_sram_port_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_data;
    logic          init_done;
    logic          sram_ceb;
    logic          sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;

    int checks = 0;
    int errors = 0;

    sram_port_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .init_done(init_done),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM macro: q is valid only after a read access, garbage otherwise.
    logic [DW-1:0] sram_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;
    always @(posedge clock) begin
        if (!sram_ceb && !sram_web) sram_mem[sram_a] <= sram_d;
        sram_q <= (!sram_ceb && sram_web) ? sram_mem[sram_a] : $urandom;
    end

    // Reference: what each address holds, plus the ordered list of reads owed.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            exp_cyc [$];
    int            resp_cyc [$];
    int            cyc = 0;
    int            resp_count = 0;
    logic [DW-1:0] last_resp = '0;

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (!init_done) check("ready_in_init", req_ready, 0);
            if (init_done) begin
                if (req_valid && req_ready) begin
                    check("ceb_fire", sram_ceb, 0);
                    check("web_fire", sram_web, !req_write);
                    check("a_fire", sram_a, req_addr);
                    if (req_write) begin
                        check("d_fire", sram_d, req_data);
                        ref_mem[req_addr] = req_data;
                    end else begin
                        exp_q.push_back(ref_mem[req_addr]);
                        exp_cyc.push_back(cyc);
                    end
                end else begin
                    check("ceb_idle", sram_ceb, 1);
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    check("resp_data", resp_data, exp_q[0]);
                    check("resp_latency", 64'((cyc - exp_cyc[0]) >= 2), 1);
                    if (resp_ready) begin
                        last_resp = resp_data;
                        resp_cyc.push_back(cyc);
                        resp_count++;
                        void'(exp_q.pop_front());
                        void'(exp_cyc.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_init();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check("init_ceb", sram_ceb, 0);
            check("init_web", sram_web, 0);
            check("init_a", sram_a, 64'(i));
            check("init_d", sram_d, 0);
            check("init_done_low", init_done, 0);
            step();
        end
        check("init_done_high", init_done, 1);
        check("ready_after_init", req_ready, 1);
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
        logic got;
        bit   done;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        waits = 0;
        done  = 0;
        while (!done) begin
            @(negedge clock);
            got = req_ready;
            step();
            if (got) done = 1;
            else begin
                waits++;
                if (waits > 40) begin
                    check("issue_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int start = resp_count;
        int n = 0;
        while (resp_count == start && n < 20) begin
            step();
            n++;
        end
        check("resp_timeout", 64'(resp_count != start), 1);
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_cyc.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    initial begin
        int w;
        int acc;
        int n;
        clear_model();
        // Reset values, with a request offered that must be ignored.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h33;
        req_data  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_ceb", sram_ceb, 1);
        step();
        reset = 1'b0;
        run_init();
        req_valid = 1'b0;

        // Cleared array reads zero.
        resp_ready = 1'b1;
        issue(1'b0, 8'h5A, '0, w);
        wait_resp();
        check("clear_read_5a", last_resp, 0);

        // Write then immediate read of the same address; exact two-cycle latency.
        issue(1'b1, 8'h5A, 32'hDEAD_BEEF, w);
        issue(1'b0, 8'h5A, '0, w);
        @(negedge clock);
        check("lat_t1_valid", resp_valid, 0);
        step();
        @(negedge clock);
        check("lat_t2_valid", resp_valid, 1);
        check("lat_t2_data", resp_data, 32'hDEAD_BEEF);
        step();

        // Back-to-back reads at full rate.
        for (int a = 0; a < 8; a++) issue(1'b1, AW'(a), DW'(a) * 32'h1111_1111, w);
        resp_cyc.delete();
        for (int a = 0; a < 8; a++) begin
            issue(1'b0, AW'(a), '0, w);
            check("b2b_no_stall", 64'(w), 0);
        end
        n = 0;
        while (resp_cyc.size() < 8 && n < 30) begin
            step();
            n++;
        end
        check("b2b_count", 64'(resp_cyc.size()), 8);
        for (int i = 1; i < resp_cyc.size(); i++)
            check("b2b_consecutive", 64'(resp_cyc[i] - resp_cyc[0]), 64'(i));

        // Backpressure: only three reads fit, head holds still.
        resp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_addr = AW'(acc + 1);
            @(negedge clock);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        check("bp_accepted", 64'(acc), 3);
        check("bp_ready_low", req_ready, 0);
        repeat (3) begin
            @(negedge clock);
            check("bp_hold_data", resp_data, 32'h1111_1111);
            check("bp_ready_held", req_ready, 0);
            step();
        end
        resp_ready = 1'b1;
        wait_resp();
        check("bp_drain0", last_resp, 32'h1111_1111);
        wait_resp();
        check("bp_drain1", last_resp, 32'h2222_2222);
        wait_resp();
        check("bp_drain2", last_resp, 32'h3333_3333);
        step();
        check("bp_ready_back", req_ready, 1);

        // Idle in RUN: no enable, no response.
        repeat (20) begin
            @(negedge clock);
            check("idle_ceb", sram_ceb, 1);
            check("idle_resp_valid", resp_valid, 0);
            step();
        end

        // Random traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            req_valid  = 1'($urandom);
            req_write  = 1'($urandom);
            req_addr   = AW'($urandom_range(0, 15));
            req_data   = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (10) step();
        check("rand_drained", 64'(exp_q.size()), 0);

        // Reset with two reads outstanding.
        resp_ready = 1'b0;
        issue(1'b0, 8'h5A, '0, w);
        issue(1'b0, 8'h5A, '0, w);
        reset = 1'b1;
        clear_model();
        #1;
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_ceb", sram_ceb, 1);
        check("mid_rst_init_done", init_done, 0);
        step();
        reset = 1'b0;
        run_init();
        check("post_rst_no_resp", resp_valid, 0);
        resp_ready = 1'b1;
        issue(1'b0, 8'h5A, '0, w);
        wait_resp();
        check("post_rst_5a", last_resp, 0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the SRAM word width.
REQ-002 The block SHALL take parameter DEPTH, default 256, as the SRAM word count.
REQ-003 The block SHALL take parameter ADDR_W, default 8, as the SRAM address width, equal to log2(DEPTH).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: the word address.
REQ-010 The block SHALL have port req_data, input, DATA_W bits: the write data.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: read data is present.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the consumer takes the response.
REQ-013 The block SHALL have port resp_data, output, DATA_W bits: the read data.
REQ-014 The block SHALL have port init_done, output, 1 bit: the array clear is complete.
REQ-015 The block SHALL have SRAM macro ports sram_ceb (output, 1 bit, active-low enable), sram_web (output, 1 bit, 0 = write), sram_a (output, ADDR_W), sram_d (output, DATA_W) and sram_q (input, DATA_W, valid the cycle after a read access, undefined otherwise).

Function
REQ-016 The block SHALL implement two states: INIT and RUN.
REQ-017 In INIT, the block SHALL drive sram_ceb=0, sram_web=0, sram_a=init counter and sram_d=0 each cycle.
REQ-018 The init counter SHALL increment by one per cycle from 0 to DEPTH-1, then move to RUN; INIT SHALL last exactly DEPTH cycles.
REQ-019 init_done SHALL be 1 only in RUN; req_ready SHALL be 0 in INIT, and request inputs in INIT SHALL be ignored.
REQ-020 In RUN, a request SHALL fire when req_valid and req_ready are both high; a fire SHALL drive combinationally sram_ceb=0, sram_web=!req_write, sram_a=req_addr and sram_d=req_data.
REQ-021 With no fire in RUN, the block SHALL drive sram_ceb=1; sram_a and sram_d are don't-care.
REQ-022 Read data SHALL be captured from sram_q in the cycle after a read fires into a 3-entry in-order response FIFO; sram_q SHALL never be sampled in any other cycle.
REQ-023 A read fired in cycle t SHALL produce resp_valid no earlier than cycle t+2, and exactly at t+2 when the FIFO is empty.
REQ-024 resp_data SHALL equal the FIFO head; the head SHALL pop on resp_valid && resp_ready; it SHALL hold stable while resp_valid && !resp_ready.
REQ-025 req_ready SHALL be a registered function of state only, with no combinational path from resp_ready or req_valid: RUN && (occupancy + reads in flight) < 3.
REQ-026 req_ready SHALL gate writes too, so that it is independent of req_write.
REQ-027 A write fired in cycle t followed by a read of the same address fired in cycle t+1 SHALL return the new data.
REQ-028 Responses SHALL return in request order; writes SHALL produce no response.
REQ-029 With resp_ready held at 1, the block SHALL sustain one read fire per cycle.

Reset
REQ-030 While reset is high, the block SHALL drive state=INIT, init counter=0, FIFO empty, in-flight flag=0, req_ready=0, resp_valid=0, init_done=0 and sram_ceb=1.
REQ-031 The cycle after reset deasserts SHALL be INIT address 0.
REQ-032 Reset mid-operation SHALL discard all pending and in-flight responses and re-clear the array.

Verification
REQ-033 Bench SHALL release reset -> 256 write cycles at addresses 0..255 with d=0, init_done=1 on cycle 256, and a read of 0x5A returns 0x00000000.
REQ-034 Bench SHALL write 0x5A=0xDEADBEEF, then read 0x5A the next cycle -> resp_valid two cycles after the read fire, with resp_data=0xDEADBEEF.
REQ-035 Bench SHALL write addresses 0..7 with value addr*0x11111111, then read 0..7 back-to-back with resp_ready=1 -> req_ready stays 1 and eight in-order responses arrive on consecutive cycles.
REQ-036 Bench SHALL hold resp_ready=0 and offer 5 reads -> exactly 3 accepted, req_ready=0, resp_data held at the first; then raise resp_ready -> 3 responses drain in order and req_ready returns to 1.
REQ-037 Bench SHALL assert reset with 2 reads in flight -> resp_valid=0 at once, INIT reruns, and earlier-written 0xDEADBEEF now reads 0x00000000.
REQ-038 Bench SHALL hold req_valid=0 in RUN -> sram_ceb=1 every cycle, with no resp_valid.
